// File: rtl/auv_heading_sequencer.sv
// auv_heading_sequencer - one heading update per pinger fix, gated by the next AUV pose strobe
module auv_heading_sequencer #(
  parameter int W            = 3,
  parameter int POSE_TIMEOUT = 64,
  parameter int UPDATE_GAP   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               fix_valid,
  output logic               fix_ready,
  input  logic [3*W-1:0]     pinger_pos,
  input  logic               pose_valid,
  input  logic [3*W-1:0]     auv_pos,
  output logic               hdg_valid,
  input  logic               hdg_ready,
  output logic [3*(W+1)-1:0] heading,
  output logic               err_timeout,
  output logic               busy,
  output logic [15:0]        update_count
);

  localparam int TW = $clog2(POSE_TIMEOUT + 1);
  localparam int GW = $clog2(UPDATE_GAP + 2);

  typedef enum logic [2:0] {IDLE, WAIT_POSE, CALC, PRESENT, GAP} state_t;

  state_t          state;
  logic [3*W-1:0]  pin_q;
  logic [3*W-1:0]  auv_q;
  logic [TW-1:0]   timer;
  logic [GW-1:0]   gap_cnt;
  logic            timer_last;

  assign timer_last  = (timer == TW'(POSE_TIMEOUT - 1));
  assign busy        = (state != IDLE);
  // fix_ready follows enable with no register so a fix is taken the same cycle enable allows it
  assign fix_ready   = (state == IDLE) && enable && !rst;
  // A pose on the final waiting cycle still wins, so the abort pulse must see pose_valid directly
  assign err_timeout = (state == WAIT_POSE) && timer_last && !pose_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pin_q        <= '0;
      auv_q        <= '0;
      timer        <= '0;
      gap_cnt      <= '0;
      heading      <= '0;
      hdg_valid    <= 1'b0;
      update_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fix_valid && enable) begin
            pin_q <= pinger_pos;
            timer <= '0;
            state <= WAIT_POSE;
          end
        end
        WAIT_POSE: begin
          if (pose_valid) begin
            auv_q <= auv_pos;
            state <= CALC;
          end else if (timer_last) begin
            state <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        CALC: begin
          // Zero-extend both operands so the W+1-bit difference is exact for every input pair
          for (int i = 0; i < 3; i++) begin
            heading[i*(W+1) +: W+1] <= {1'b0, pin_q[i*W +: W]} - {1'b0, auv_q[i*W +: W]};
          end
          hdg_valid <= 1'b1;
          state     <= PRESENT;
        end
        PRESENT: begin
          if (hdg_ready) begin
            hdg_valid    <= 1'b0;
            update_count <= update_count + 16'd1;
            gap_cnt      <= '0;
            state        <= (UPDATE_GAP > 0) ? GAP : IDLE;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(UPDATE_GAP - 1)) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_auv_heading_sequencer.sv
// tb/tb_auv_heading_sequencer.sv - randomized timeline-model bench for auv_heading_sequencer
module tb_auv_heading_sequencer;

  localparam int TO  = 64;
  localparam int GAP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0, fix_valid = 1'b0, pose_valid = 1'b0, hdg_ready = 1'b0;
  logic [8:0]  pinger_pos = '0, auv_pos = '0;
  logic        fix_ready, hdg_valid, err_timeout, busy;
  logic [11:0] heading;
  logic [15:0] update_count;

  logic        z_enable = 1'b0, z_fix_valid = 1'b0, z_pose_valid = 1'b0, z_hdg_ready = 1'b0;
  logic [8:0]  z_pinger_pos = '0, z_auv_pos = '0;
  logic        z_fix_ready, z_hdg_valid, z_err_timeout, z_busy;
  logic [11:0] z_heading;
  logic [15:0] z_update_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  auv_heading_sequencer #(.W(3), .POSE_TIMEOUT(TO), .UPDATE_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fix_valid(fix_valid), .fix_ready(fix_ready),
    .pinger_pos(pinger_pos), .pose_valid(pose_valid), .auv_pos(auv_pos),
    .hdg_valid(hdg_valid), .hdg_ready(hdg_ready), .heading(heading),
    .err_timeout(err_timeout), .busy(busy), .update_count(update_count)
  );

  auv_heading_sequencer #(.W(3), .POSE_TIMEOUT(TO), .UPDATE_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .enable(z_enable), .fix_valid(z_fix_valid), .fix_ready(z_fix_ready),
    .pinger_pos(z_pinger_pos), .pose_valid(z_pose_valid), .auv_pos(z_auv_pos),
    .hdg_valid(z_hdg_valid), .hdg_ready(z_hdg_ready), .heading(z_heading),
    .err_timeout(z_err_timeout), .busy(z_busy), .update_count(z_update_count)
  );

  // Timeline model: an update is described by when its fix, pose and handshake happened
  int          cyc;
  bit          m_busy;
  int          t_acc, t_pose, t_hs;
  logic [8:0]  m_p, m_a;
  logic [11:0] m_head;
  logic [15:0] m_cnt;

  function automatic logic [11:0] diff(input logic [8:0] p, input logic [8:0] a);
    logic [11:0] r;
    int d;
    for (int i = 0; i < 3; i++) begin
      d = int'(p[i*3 +: 3]) - int'(a[i*3 +: 3]);
      r[i*4 +: 4] = d[3:0];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; m_busy = 0; t_acc = -1; t_pose = -1; t_hs = -1;
    m_p = '0; m_a = '0; m_head = '0; m_cnt = '0;
  endtask

  task automatic check_outputs();
    bit exp_valid, exp_err;
    exp_valid = m_busy && t_pose >= 0 && t_hs < 0 && cyc >= t_pose + 2;
    exp_err   = m_busy && t_pose < 0 && cyc == t_acc + TO && !pose_valid;
    chk("hdg_valid", hdg_valid, exp_valid);
    chk("err_timeout", err_timeout, exp_err);
    chk("busy", busy, m_busy);
    chk("fix_ready", fix_ready, !m_busy && enable);
    chk("heading", heading, m_head);
    chk("update_count", update_count, m_cnt);
  endtask

  task automatic model_step();
    if (!m_busy) begin
      if (enable && fix_valid) begin
        m_busy = 1; t_acc = cyc; m_p = pinger_pos; t_pose = -1; t_hs = -1;
      end
    end else if (t_pose < 0) begin
      if (pose_valid) begin
        t_pose = cyc; m_a = auv_pos;
      end else if (cyc == t_acc + TO) begin
        m_busy = 0;
      end
    end else if (t_hs < 0) begin
      if (cyc == t_pose + 1) m_head = diff(m_p, m_a);
      else if (cyc >= t_pose + 2 && hdg_ready) begin
        t_hs = cyc; m_cnt = m_cnt + 16'd1;
        if (GAP == 0) m_busy = 0;
      end
    end else if (cyc == t_hs + GAP) begin
      m_busy = 0;
    end
    cyc++;
  endtask

  task automatic tick();
    #1 check_outputs();
    model_step();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int b = 0;
    fix_valid = 0; pose_valid = 0; enable = 1;
    while (m_busy && b < 100) begin
      tick();
      b++;
    end
    if (m_busy) begin
      total++; bad++;
      $display("FAIL wait_idle: model still busy after %0d cycles", b);
    end
  endtask

  task automatic run_one(input logic [8:0] p, input logic [8:0] a, input int delay,
                         input logic [11:0] exp_head, input string name);
    wait_idle();
    fix_valid = 1; pinger_pos = p; hdg_ready = 1;
    tick();
    fix_valid = 0;
    repeat (delay) tick();
    pose_valid = 1; auv_pos = a;
    tick();
    pose_valid = 0;
    tick();
    #1 chk({name, "_valid"}, hdg_valid, 1);
    chk({name, "_heading"}, heading, exp_head);
    tick();
    hdg_ready = 0;
  endtask

  task automatic pulse_reset(input string name);
    #2 rst = 1;
    #1 chk({name, "_busy"}, busy, 0);
    chk({name, "_hdg_valid"}, hdg_valid, 0);
    chk({name, "_fix_ready"}, fix_ready, 0);
    chk({name, "_count"}, update_count, 0);
    chk({name, "_heading"}, heading, 0);
    chk({name, "_err"}, err_timeout, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  initial begin
    int first, n;
    logic [11:0] held;
    model_reset();
    repeat (2) @(negedge clk);
    enable = 1;
    #1 chk("reset_fix_ready", fix_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_count", update_count, 0);
    chk("reset_heading", heading, 0);
    rst = 0;
    @(negedge clk);
    model_reset();

    run_one({3'd7, 3'd2, 3'd5}, {3'd7, 3'd6, 3'd1}, 2, 12'h0C4, "basic");
    #1 chk("basic_count", update_count, 1);
    run_one({3'd7, 3'd0, 3'd7}, {3'd7, 3'd7, 3'd0}, 0, 12'h097, "extreme");

    // Pose never arrives: abort pulse on the 64th waiting cycle
    wait_idle();
    fix_valid = 1; pinger_pos = 9'h0AB;
    tick();
    fix_valid = 0; first = -1;
    for (int k = 1; k <= 70; k++) begin
      #1 if (err_timeout && first < 0) first = k;
      tick();
    end
    chk("timeout_cycle", first, TO);

    // Pose on the timeout cycle wins
    fix_valid = 1; pinger_pos = {3'd1, 3'd1, 3'd1}; hdg_ready = 1;
    tick();
    fix_valid = 0;
    repeat (TO - 1) tick();
    pose_valid = 1; auv_pos = {3'd0, 3'd0, 3'd3};
    #1 chk("late_pose_no_err", err_timeout, 0);
    tick();
    pose_valid = 0;
    tick();
    #1 chk("late_pose_valid", hdg_valid, 1);
    chk("late_pose_heading", heading, 12'h11E);
    tick();
    hdg_ready = 0;

    // Backpressure then gap length
    wait_idle();
    fix_valid = 1; pinger_pos = {3'd3, 3'd4, 3'd5};
    tick();
    fix_valid = 0; pose_valid = 1; auv_pos = {3'd6, 3'd2, 3'd0};
    tick();
    pose_valid = 0;
    tick();
    fix_valid = 1; pinger_pos = 9'h1FF;
    #1 held = heading;
    chk("bp_heading", held, 12'hD25);
    for (int k = 0; k < 10; k++) begin
      #1 chk("bp_stable", heading, held);
      chk("bp_fix_ready", fix_ready, 0);
      chk("bp_valid", hdg_valid, 1);
      tick();
    end
    hdg_ready = 1;
    tick();
    hdg_ready = 0; fix_valid = 0; n = 0;
    for (int k = 0; k < 20; k++) begin
      #1 if (fix_ready) break;
      n++;
      tick();
    end
    chk("gap_len", n, GAP);

    // Zero-gap instance: ready again the cycle after the handshake
    z_enable = 1; z_fix_valid = 1; z_pinger_pos = {3'd0, 3'd0, 3'd3};
    tick();
    z_fix_valid = 0; z_pose_valid = 1; z_auv_pos = {3'd0, 3'd0, 3'd5};
    tick();
    z_pose_valid = 0;
    tick();
    z_hdg_ready = 1;
    #1 chk("gap0_valid", z_hdg_valid, 1);
    chk("gap0_heading", z_heading, 12'h00E);
    tick();
    z_hdg_ready = 0;
    #1 chk("gap0_fix_ready", z_fix_ready, 1);
    chk("gap0_count", z_update_count, 1);
    z_enable = 0;

    // enable low blocks acceptance
    wait_idle();
    enable = 0; fix_valid = 1;
    for (int k = 0; k < 6; k++) begin
      #1 chk("dis_fix_ready", fix_ready, 0);
      tick();
    end
    fix_valid = 0; enable = 1;

    // Reset in WAIT_POSE and in PRESENT
    fix_valid = 1; pinger_pos = 9'h055;
    tick();
    fix_valid = 0;
    tick();
    pulse_reset("rst_wait");
    fix_valid = 1; hdg_ready = 0;
    tick();
    fix_valid = 0; pose_valid = 1; auv_pos = 9'h0AA;
    tick();
    pose_valid = 0;
    repeat (3) tick();
    pulse_reset("rst_present");

    // Randomized traffic against the timeline model
    for (int k = 0; k < 4000; k++) begin
      enable     = ($urandom % 10) != 0;
      fix_valid  = $urandom % 2;
      pinger_pos = 9'($urandom);
      pose_valid = ($urandom % 30) == 0;
      auv_pos    = 9'($urandom);
      hdg_ready  = ($urandom % 3) != 0;
      tick();
    end

    // Counter wrap
    wait_idle();
    force dut.update_count = 16'hFFFF;
    #1 release dut.update_count;
    m_cnt = 16'hFFFF;
    run_one({3'd0, 3'd0, 3'd0}, {3'd0, 3'd0, 3'd0}, 1, 12'h000, "wrap");
    #1 chk("wrap_count", update_count, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
